arithmetic_unit: RTL and testbench
==================================

// Module: arithmetic_unit
// PURPOSE
// - Execute-stage integer unit: RV32I ALU ops plus RV32M MUL/DIV/REM behind a valid/ready handshake.
// - ALU ops: 1-cycle latency. MUL ops: MUL_LATENCY cycles. DIV/REM: fixed multicycle latency.
// - Exactly one operation in flight. flush kills the in-flight operation.
// PARAMETERS
// - DATA_WIDTH   32  operand/result width; power of two, >= 8
// - ENABLE_M     1   1: RV32M codes legal; 0: funct7=0x01 codes report illegal
// - MUL_LATENCY  2   accept-to-out_valid cycles for MUL*; >= 1
// PORTS
// - clk            in   1           single clock, all state on rising edge
// - reset          in   1           synchronous, active-high
// - flush          in   1           drop in-flight op; no accept this cycle
// - in_valid       in   1           request present
// - in_ready       out  1           unit can accept this cycle
// - lhs            in   DATA_WIDTH  rs1 value
// - rhs            in   DATA_WIDTH  rs2 value or decoded immediate
// - operation      in   3           funct3
// - metadata       in   7           funct7 / imm[11:5], zero if n/a
// - out_valid      out  1           result present
// - out_ready      in   1           consumer takes result
// - result         out  DATA_WIDTH  result; held stable while out_valid && !out_ready
// - code_legal     out  1           0 = unsupported {operation,metadata}; qualifies result
// BEHAVIOUR
// - Clock/reset: one clock; reset synchronous active-high; reset wins over all inputs, aborts any op.
// - Reset values: out_valid=0, result=0, code_legal=0, state=IDLE. in_ready=1 after reset unless flush.
// - Handshakes: accept = in_valid && in_ready; output taken when out_valid && out_ready.
// - in_ready = !flush && (IDLE || (DONE && out_ready)); back-to-back issue, one op per cycle on ALU ops.
// - States IDLE -> ALU/MUL/DIV on accept; ALU path: DONE next cycle; MUL: count MUL_LATENCY-1 then DONE.
// - DIV: DATA_WIDTH+1 cycles (setup/sign-fix + DATA_WIDTH restoring iterations), then DONE.
// - DONE & out_ready & !in_valid -> IDLE; DONE & out_ready & in_valid -> next op state.
// - Latency: out_valid high in cycle ALU=1, MUL=MUL_LATENCY, DIV/REM=DATA_WIDTH+1 after accept edge.
// - flush: any state -> IDLE next edge, out_valid=0, result discarded; overrides simultaneous out_ready.
// - Ops (funct7=0x00 unless noted): add; sub (0x20); xor; or; and; sll; srl; sra (0x20); slt; sltu.
// - Shifts use rhs[$clog2(DATA_WIDTH)-1:0] only; upper rhs bits ignored.
// - slt/sltu return 1 or 0 zero-extended to DATA_WIDTH.
// - funct7=0x01: mul (low half), mulh (s*s), mulhsu (s*u), mulhu (u*u): high half of 2*DATA_WIDTH product.
// - funct7=0x01: div, divu, rem, remu.
// - Divide by zero: quotient all-ones, remainder = lhs. Signed MIN / -1: quotient MIN, remainder 0.
// - Special divide cases keep full DIV latency (deterministic timing).
// - Illegal code: takes the 1-cycle ALU path; result=0, code_legal=0, out_valid still asserted.
// - No X on result in any state.
// STRUCTURE
// - arithmetic_pkg: funct3 enum (op_t), FUNCT7_BASE=7'h00, FUNCT7_ALT=7'h20, FUNCT7_MULDIV=7'h01.
// - arithmetic_pkg: state_t {IDLE, ALU, MUL, DIV, DONE}.
// - Sub-module arithmetic_divider: start, signed flag, busy/done; outputs quotient and remainder.
// - The top module contains the ALU, the MUL pipeline, the FSM and the output register.
// TESTING
// - add 5+7 accept, out_ready=1: result=12, code_legal=1 one cycle later; 4 back-to-back adds: 1/cycle.
// - sub 0-1 -> 0xFFFFFFFF; sra 0x80000000 by rhs=0x21 -> 0xC0000000 (shamt=1); sltu 1<0xFFFFFFFF -> 1.
// - mulh 0x80000000*0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF^2 -> 0xFFFFFFFE; result at cycle MUL_LATENCY.
// - div 7/0 -> 0xFFFFFFFF; rem 7/0 -> 7; div 0x80000000/-1 -> 0x80000000; rem -> 0.
// - Each DIV/REM check: out_valid exactly at cycle 33; in_ready low throughout.
// - Hold out_ready=0 for 5 cycles at DONE: result/out_valid stable, in_ready=0; release -> next op accepted same cycle.
// - flush at DIV cycle 10: out_valid never rises, IDLE next cycle.
// - reset at MUL cycle 1: all outputs reset values next cycle.
// - Illegal {0x0,0x7F}: out_valid=1 next cycle, code_legal=0, result=0.
// - ENABLE_M=0 mul: out_valid=1 next cycle, code_legal=0.

Source files
------------

// File: rtl/arithmetic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arithmetic_pkg
// Description : Shared types and constants for the execute-stage integer unit.
//               funct3 encodings for the base ALU and the M-extension, the
//               funct7 groups that select between them, and the FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package arithmetic_pkg;

    // funct3 encodings of the base integer ops (funct7 = BASE or ALT)
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SLL  = 3'b001,
        OP_SLT  = 3'b010,
        OP_SLTU = 3'b011,
        OP_XOR  = 3'b100,
        OP_SRL  = 3'b101,
        OP_OR   = 3'b110,
        OP_AND  = 3'b111
    } op_t;

    // funct3 encodings of the multiply/divide ops (funct7 = MULDIV)
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    localparam logic [6:0] FUNCT7_BASE   = 7'h00;
    localparam logic [6:0] FUNCT7_ALT    = 7'h20;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ALU  = 3'd1,
        MUL  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/arithmetic_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : arithmetic_unit_if
// Description : Request/response bundle of the integer unit.
//               Request : in_valid, in_ready, lhs, rhs, operation, metadata
//               Response: out_valid, out_ready, result, code_legal
//               master = issuing stage, slave = arithmetic_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface arithmetic_unit_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] lhs;
    logic [DATA_WIDTH-1:0] rhs;
    logic [2:0]            operation;
    logic [6:0]            metadata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  code_legal;

    modport master (
        output in_valid, lhs, rhs, operation, metadata, out_ready,
        input  in_ready, out_valid, result, code_legal
    );

    modport slave (
        input  in_valid, lhs, rhs, operation, metadata, out_ready,
        output in_ready, out_valid, result, code_legal
    );

endinterface
`default_nettype wire

// File: rtl/arithmetic_divider.sv
`default_nettype none
// ============================================================================
// Module      : arithmetic_divider
// Description : Restoring divider, signed or unsigned. The start edge captures
//               operand magnitudes and sign flags; DATA_WIDTH iteration edges
//               follow. done is high during the last iteration cycle and
//               quotient/remainder then carry the final, sign-corrected values
//               so the caller can register them on that same edge.
// Ports       : clk, reset (sync, active-high), abort (drop current op),
//               start, is_signed, dividend, divisor -> busy, done,
//               quotient, remainder
// Revision    : 1.0 - initial release
// ============================================================================
module arithmetic_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  abort,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int                  c_cnt_w = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DATA_WIDTH - 1);

    logic                  r_busy;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_div;
    logic [DATA_WIDTH-1:0] r_lhs;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_zero;

    logic                  w_lhs_neg;
    logic                  w_rhs_neg;
    logic [DATA_WIDTH-1:0] w_lhs_abs;
    logic [DATA_WIDTH-1:0] w_rhs_abs;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_quo_next;

    assign w_lhs_neg = is_signed & dividend[DATA_WIDTH-1];
    assign w_rhs_neg = is_signed & divisor[DATA_WIDTH-1];
    assign w_lhs_abs = w_lhs_neg ? -dividend : dividend;
    assign w_rhs_abs = w_rhs_neg ? -divisor  : divisor;

    // One restoring step: shift in the next dividend bit, subtract when no borrow.
    // The partial remainder stays below the divisor, so DATA_WIDTH bits hold it.
    assign w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_div};
    assign w_ge       = ~w_diff[DATA_WIDTH];
    assign w_rem_next = w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_quo_next = {r_quo[DATA_WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_lhs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
        end else if (abort) begin
            r_busy <= 1'b0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_quo   <= w_lhs_abs;
            r_rem   <= '0;
            r_div   <= w_rhs_abs;
            r_lhs   <= dividend;
            r_neg_q <= w_lhs_neg ^ w_rhs_neg;
            r_neg_r <= w_lhs_neg;
            r_zero  <= (divisor == '0);
        end else if (r_busy) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == c_last);

    // Divide by zero is overridden outright; signed MIN / -1 falls out of the
    // magnitude path naturally (2^(W-1) negated wraps back to MIN, remainder 0).
    assign quotient  = r_zero  ? {DATA_WIDTH{1'b1}} :
                       r_neg_q ? -w_quo_next : w_quo_next;
    assign remainder = r_zero  ? r_lhs :
                       r_neg_r ? -w_rem_next : w_rem_next;

endmodule
`default_nettype wire

// File: rtl/arithmetic_unit.sv
`default_nettype none
// ============================================================================
// Module      : arithmetic_unit
// Description : Execute-stage integer unit: base ALU ops in one cycle,
//               MUL* in MUL_LATENCY cycles, DIV/REM in DATA_WIDTH+1 cycles,
//               one operation in flight, valid/ready on both sides.
// Ports       : clk, reset (sync, active-high), flush (kill in-flight op),
//               bus (arithmetic_unit_if.slave): in_valid/in_ready, lhs, rhs,
//               operation (funct3), metadata (funct7), out_valid/out_ready,
//               result, code_legal
// Revision    : 1.0 - initial release
// ============================================================================
module arithmetic_unit
    import arithmetic_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter bit ENABLE_M    = 1'b1,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    arithmetic_unit_if.slave bus
);

    localparam int c_shamt_w   = $clog2(DATA_WIDTH);
    localparam int c_mul_cnt_w = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam int c_mul_last_i = (MUL_LATENCY > 2) ? (MUL_LATENCY - 2) : 0;
    localparam logic [c_mul_cnt_w-1:0] c_mul_last = c_mul_cnt_w'(c_mul_last_i);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_code_legal;
    md_op_t                  r_mul_op;
    logic [DATA_WIDTH-1:0]   r_mul_lhs;
    logic [DATA_WIDTH-1:0]   r_mul_rhs;
    logic [c_mul_cnt_w-1:0]  r_mul_cnt;
    logic                    r_div_rem;

    op_t                     w_op;
    md_op_t                  w_md_op;
    logic                    w_accept;
    logic                    w_is_base;
    logic                    w_is_alt;
    logic                    w_is_md;
    logic                    w_legal;
    logic                    w_go_mul;
    logic                    w_go_div;
    logic [c_shamt_w-1:0]    w_shamt;
    logic [DATA_WIDTH-1:0]   w_sra;
    logic [DATA_WIDTH-1:0]   w_alu_result;
    logic                    w_div_busy;
    logic                    w_div_done;
    logic [DATA_WIDTH-1:0]   w_div_quo;
    logic [DATA_WIDTH-1:0]   w_div_rem;
    logic [DATA_WIDTH-1:0]   w_div_result;

    // Product sign handling: extend each operand to 2*W+2 bits with its own
    // signedness so one signed multiply covers MUL/MULH/MULHSU/MULHU.
    function automatic logic [DATA_WIDTH-1:0] mul_calc(
        input md_op_t                op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic                          sign_a;
        logic                          sign_b;
        logic signed [2*DATA_WIDTH+1:0] ext_a;
        logic signed [2*DATA_WIDTH+1:0] ext_b;
        logic signed [2*DATA_WIDTH+1:0] prod;
        sign_a = ((op == MD_MULH) || (op == MD_MULHSU)) && a[DATA_WIDTH-1];
        sign_b = (op == MD_MULH) && b[DATA_WIDTH-1];
        ext_a  = {{(DATA_WIDTH+2){sign_a}}, a};
        ext_b  = {{(DATA_WIDTH+2){sign_b}}, b};
        prod   = ext_a * ext_b;
        return (op == MD_MUL) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    assign w_op    = op_t'(bus.operation);
    assign w_md_op = md_op_t'(bus.operation);

    assign bus.in_ready = !flush && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Code decode: ALT funct7 is only meaningful for SUB and SRA.
    assign w_is_base = (bus.metadata == FUNCT7_BASE);
    assign w_is_alt  = (bus.metadata == FUNCT7_ALT);
    assign w_is_md   = (bus.metadata == FUNCT7_MULDIV) && ENABLE_M;
    assign w_legal   = w_is_base || w_is_md ||
                       (w_is_alt && ((w_op == OP_ADD) || (w_op == OP_SRL)));
    assign w_go_mul  = w_is_md && !bus.operation[2];
    assign w_go_div  = w_is_md &&  bus.operation[2];

    assign w_shamt = bus.rhs[c_shamt_w-1:0];
    assign w_sra   = $signed(bus.lhs) >>> w_shamt;

    // Illegal codes fall through here too and produce zero.
    always_comb begin
        w_alu_result = '0;
        if (w_legal && !w_is_md) begin
            case (w_op)
                OP_ADD:  w_alu_result = w_is_alt ? (bus.lhs - bus.rhs) : (bus.lhs + bus.rhs);
                OP_SLL:  w_alu_result = bus.lhs << w_shamt;
                OP_SLT:  w_alu_result[0] = $signed(bus.lhs) < $signed(bus.rhs);
                OP_SLTU: w_alu_result[0] = bus.lhs < bus.rhs;
                OP_XOR:  w_alu_result = bus.lhs ^ bus.rhs;
                OP_SRL:  w_alu_result = w_is_alt ? w_sra : (bus.lhs >> w_shamt);
                OP_OR:   w_alu_result = bus.lhs | bus.rhs;
                OP_AND:  w_alu_result = bus.lhs & bus.rhs;
                default: w_alu_result = '0;
            endcase
        end
    end

    arithmetic_divider #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .abort     (flush),
        .start     (w_accept && w_go_div),
        .is_signed (!bus.operation[0]),
        .dividend  (bus.lhs),
        .divisor   (bus.rhs),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    assign w_div_result = r_div_rem ? w_div_rem : w_div_quo;

    // ALU results are registered on the accept edge itself, so ALU ops go
    // straight to DONE; the ALU encoding is kept in state_t but never entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_result     <= '0;
            r_code_legal <= 1'b0;
            r_mul_op     <= MD_MUL;
            r_mul_lhs    <= '0;
            r_mul_rhs    <= '0;
            r_mul_cnt    <= '0;
            r_div_rem    <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_code_legal <= w_legal;
                        if (w_go_div) begin
                            r_div_rem <= bus.operation[1];
                            r_state   <= DIV;
                        end else if (w_go_mul) begin
                            if (MUL_LATENCY == 1) begin
                                r_result <= mul_calc(w_md_op, bus.lhs, bus.rhs);
                                r_state  <= DONE;
                            end else begin
                                r_mul_op  <= w_md_op;
                                r_mul_lhs <= bus.lhs;
                                r_mul_rhs <= bus.rhs;
                                r_mul_cnt <= '0;
                                r_state   <= MUL;
                            end
                        end else begin
                            r_result <= w_alu_result;
                            r_state  <= DONE;
                        end
                    end else if ((r_state == DONE) && bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                MUL: begin
                    if (r_mul_cnt == c_mul_last) begin
                        r_result <= mul_calc(r_mul_op, r_mul_lhs, r_mul_rhs);
                        r_state  <= DONE;
                    end else begin
                        r_mul_cnt <= r_mul_cnt + c_mul_cnt_w'(1);
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_result <= w_div_result;
                        r_state  <= DONE;
                    end else if (!w_div_busy) begin
                        // divider lost its operation; recover rather than hang
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid  = (r_state == DONE);
    assign bus.result     = r_result;
    assign bus.code_legal = r_code_legal;

endmodule
`default_nettype wire

// File: tb/tb_arithmetic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_arithmetic_unit
// Description : Self-checking bench for arithmetic_unit (32-bit, MUL_LATENCY=2)
//               with a second instance built with ENABLE_M=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arithmetic_unit;

    typedef struct {
        logic [2:0]  op;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        legal;
        int          lat;
    } vec_t;

    localparam int NV = 27;

    logic clk;
    logic reset;
    logic flush;
    logic flush_m0;

    int checks;
    int failures;

    vec_t vecs [NV];

    arithmetic_unit_if #(.DATA_WIDTH(32)) bus ();
    arithmetic_unit_if #(.DATA_WIDTH(32)) bus_m0 ();

    arithmetic_unit #(
        .DATA_WIDTH  (32),
        .ENABLE_M    (1'b1),
        .MUL_LATENCY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    arithmetic_unit #(
        .DATA_WIDTH  (32),
        .ENABLE_M    (1'b0),
        .MUL_LATENCY (2)
    ) dut_m0 (
        .clk   (clk),
        .reset (reset),
        .flush (flush_m0),
        .bus   (bus_m0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  wait_cnt;
        logic ready_seen;
        logic seen;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        flush_m0 = 1'b0;
        bus.in_valid = 1'b0;  bus.lhs = '0; bus.rhs = '0;
        bus.operation = '0;   bus.metadata = '0; bus.out_ready = 1'b0;
        bus_m0.in_valid = 1'b0; bus_m0.lhs = '0; bus_m0.rhs = '0;
        bus_m0.operation = '0;  bus_m0.metadata = '0; bus_m0.out_ready = 1'b0;

        //            op      f7     a             b             exp           legal lat
        vecs[0]  = '{3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       1'b1, 1};
        vecs[1]  = '{3'b000, 7'h20, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b1, 1};
        vecs[2]  = '{3'b101, 7'h20, 32'h80000000, 32'h21,       32'hC0000000, 1'b1, 1};
        vecs[3]  = '{3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b1, 1};
        vecs[4]  = '{3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1};
        vecs[5]  = '{3'b101, 7'h00, 32'h80000000, 32'h21,       32'h40000000, 1'b1, 1};
        vecs[6]  = '{3'b001, 7'h00, 32'd1,        32'h3F,       32'h80000000, 1'b1, 1};
        vecs[7]  = '{3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1};
        vecs[8]  = '{3'b110, 7'h00, 32'hF0,       32'h0F,       32'hFF,       1'b1, 1};
        vecs[9]  = '{3'b111, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b1, 1};
        vecs[10] = '{3'b000, 7'h01, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b1, 2};
        vecs[11] = '{3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1, 2};
        vecs[12] = '{3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 2};
        vecs[13] = '{3'b010, 7'h01, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b1, 2};
        vecs[14] = '{3'b100, 7'h01, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b1, 33};
        vecs[15] = '{3'b110, 7'h01, 32'd7,        32'd0,        32'd7,        1'b1, 33};
        vecs[16] = '{3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33};
        vecs[17] = '{3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 33};
        vecs[18] = '{3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1, 33};
        vecs[19] = '{3'b110, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b1, 33};
        vecs[20] = '{3'b101, 7'h01, 32'd100,      32'd7,        32'd14,       1'b1, 33};
        vecs[21] = '{3'b111, 7'h01, 32'd100,      32'd7,        32'd2,        1'b1, 33};
        vecs[22] = '{3'b010, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1};
        vecs[23] = '{3'b110, 7'h00, 32'd1,        32'd2,        32'd3,        1'b1, 1};
        vecs[24] = '{3'b000, 7'h7F, 32'd1,        32'd2,        32'd0,        1'b0, 1};
        vecs[25] = '{3'b000, 7'h00, 32'd9,        32'd9,        32'd18,       1'b1, 1};
        vecs[26] = '{3'b001, 7'h20, 32'd1,        32'd2,        32'd0,        1'b0, 1};

        // ---------------- reset state ----------------
        tick();
        tick();
        check("reset_out_valid",  {31'd0, bus.out_valid},  32'd0);
        check("reset_result",     bus.result,              32'd0);
        check("reset_code_legal", {31'd0, bus.code_legal}, 32'd0);
        check("reset_m0_valid",   {31'd0, bus_m0.out_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("reset_in_ready",   {31'd0, bus.in_ready},   32'd1);

        // ---------------- back-to-back adds ----------------
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.operation = 3'b000;
        bus.metadata  = 7'h00;
        for (int k = 1; k <= 4; k++) begin
            bus.lhs = k;
            bus.rhs = k;
            tick();
            check("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("b2b_result",    bus.result,             32'(2 * k));
        end
        bus.in_valid = 1'b0;
        tick();
        check("b2b_idle_valid", {31'd0, bus.out_valid}, 32'd0);

        // ---------------- output stall ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.lhs = 32'd10;
        bus.rhs = 32'd20;
        tick();
        bus.lhs = 32'd1;
        bus.rhs = 32'd2;
        for (int k = 0; k < 5; k++) begin
            check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_result",    bus.result,             32'd30);
            check("stall_in_ready",  {31'd0, bus.in_ready},  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("stall_release_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("stall_next_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("stall_next_result", bus.result,             32'd3);
        bus.in_valid = 1'b0;
        tick();
        check("stall_idle_valid", {31'd0, bus.out_valid}, 32'd0);

        // ---------------- reset during MUL ----------------
        bus.in_valid  = 1'b1;
        bus.operation = 3'b000;
        bus.metadata  = 7'h01;
        bus.lhs = 32'd3;
        bus.rhs = 32'd4;
        tick();
        bus.in_valid = 1'b0;
        check("mulrst_c1_valid", {31'd0, bus.out_valid}, 32'd0);
        reset = 1'b1;
        tick();
        check("mulrst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        check("mulrst_result",     bus.result,              32'd0);
        check("mulrst_code_legal", {31'd0, bus.code_legal}, 32'd0);
        reset = 1'b0;
        tick();
        check("mulrst_after_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mulrst_in_ready",    {31'd0, bus.in_ready},  32'd1);

        // ---------------- flush during DIV ----------------
        bus.in_valid  = 1'b1;
        bus.operation = 3'b100;
        bus.metadata  = 7'h01;
        bus.lhs = 32'd100;
        bus.rhs = 32'd7;
        tick();
        bus.in_valid = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            tick();
            cyc++;
        end
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_idle_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_never_valid", {31'd0, seen}, 32'd0);

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            wait_cnt = 0;
            while (!bus.in_ready && wait_cnt < 50) begin
                tick();
                wait_cnt++;
            end
            check($sformatf("vec%0d_ready", i), {31'd0, bus.in_ready}, 32'd1);
            bus.operation = vecs[i].op;
            bus.metadata  = vecs[i].f7;
            bus.lhs       = vecs[i].a;
            bus.rhs       = vecs[i].b;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            cyc = 1;
            ready_seen = 1'b0;
            while (!bus.out_valid && cyc < 100) begin
                if (bus.in_ready) ready_seen = 1'b1;
                tick();
                cyc++;
            end
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
            check($sformatf("vec%0d_code_legal", i), {31'd0, bus.code_legal}, {31'd0, vecs[i].legal});
            if (vecs[i].lat > 1) begin
                check($sformatf("vec%0d_busy_ready", i), {31'd0, ready_seen}, 32'd0);
            end
            tick();
        end

        // ---------------- ENABLE_M = 0 instance ----------------
        bus_m0.out_ready = 1'b1;
        bus_m0.in_valid  = 1'b1;
        bus_m0.operation = 3'b000;
        bus_m0.metadata  = 7'h00;
        bus_m0.lhs = 32'd3;
        bus_m0.rhs = 32'd4;
        tick();
        check("m0_add_valid",  {31'd0, bus_m0.out_valid},  32'd1);
        check("m0_add_result", bus_m0.result,              32'd7);
        check("m0_add_legal",  {31'd0, bus_m0.code_legal}, 32'd1);
        bus_m0.metadata = 7'h01;
        tick();
        check("m0_mul_valid",  {31'd0, bus_m0.out_valid},  32'd1);
        check("m0_mul_result", bus_m0.result,              32'd0);
        check("m0_mul_legal",  {31'd0, bus_m0.code_legal}, 32'd0);
        bus_m0.in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
